// File: rtl/exe_pip1_pkg.sv
// Shared micro-op codes and FSM state type for the pipeline-1 execute stage.
package exe_pip1_pkg;

  localparam logic [5:0] UOP_ADD   = 6'd0;
  localparam logic [5:0] UOP_SUB   = 6'd1;
  localparam logic [5:0] UOP_AND   = 6'd2;
  localparam logic [5:0] UOP_OR    = 6'd3;
  localparam logic [5:0] UOP_XOR   = 6'd4;
  localparam logic [5:0] UOP_SLT   = 6'd5;
  localparam logic [5:0] UOP_SLTU  = 6'd6;
  localparam logic [5:0] UOP_SLL   = 6'd7;
  localparam logic [5:0] UOP_SRL   = 6'd8;
  localparam logic [5:0] UOP_SRA   = 6'd9;
  localparam logic [5:0] UOP_ADDI  = 6'd10;
  localparam logic [5:0] UOP_LUI   = 6'd11;
  localparam logic [5:0] UOP_AUIPC = 6'd12;
  localparam logic [5:0] UOP_JAL   = 6'd13;
  localparam logic [5:0] UOP_BEQ   = 6'd14;
  localparam logic [5:0] UOP_BNE   = 6'd15;
  localparam logic [5:0] UOP_MUL   = 6'd16;
  localparam logic [5:0] UOP_NOP   = 6'h3F;

  typedef enum logic {
    IDLE,
    MUL
  } state_e;

endpackage

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, the low Width bits of a*b
// are presented on product_o in the same cycle done_o is high.
module mul_seq #(
  parameter int unsigned Width = 32,
  parameter int unsigned Iter  = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             done_o,
  output logic [Width-1:0] product_o
);

  localparam int unsigned CntW = $clog2(Iter);

  logic [Width-1:0] mcand_q, mplier_q, acc_q, acc_d;
  logic [CntW-1:0]  cnt_q;
  logic             run_q;

  // The final step's sum is exposed directly so the product can be consumed on the last edge.
  always_comb begin
    acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    done_o    = run_q && (cnt_q == CntW'(Iter - 1));
    product_o = acc_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (clear_i) begin
      run_q <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CntW'(1);
      if (done_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/exe_pip1.sv
// Pipeline-1 execute stage: E register, single-cycle ALU/branch resolve, iterative multiply,
// and a registered W stage broadcasting results back to the reservation station.
module exe_pip1
  import exe_pip1_pkg::*;
#(
  parameter int unsigned W_PD_UOPS  = 6,
  parameter int unsigned W_PD_DATA  = 32,
  parameter int unsigned W_PA_REG   = 5,
  parameter int unsigned W_AA_INSTR = 32,
  parameter int unsigned MUL_ITER   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [W_PD_UOPS-1:0]  DFI_PD_uops,
  input  logic [W_PD_DATA-1:0]  DFI_PD_rs,
  input  logic [W_PD_DATA-1:0]  DFI_PD_rt,
  input  logic [W_PD_DATA-1:0]  DFI_PD_imm,
  input  logic [W_AA_INSTR-1:0] DFI_AA_pc,
  input  logic [W_PA_REG-1:0]   DFI_PA_rd,
  input  logic                  CFI_PC_clear,
  output logic                  CFO_PC_busy,
  output logic [W_PD_DATA-1:0]  CDO_PD_upt,
  output logic [W_PA_REG-1:0]   CDO_PA_upt,
  output logic                  CDO_PC_upv,
  output logic                  CFO_PC_redirect,
  output logic [W_AA_INSTR-1:0] DFO_AA_target
);

  state_e                state_q;
  logic                  e_vld_q;
  logic [W_PD_UOPS-1:0]  e_uops_q;
  logic [W_PD_DATA-1:0]  e_rs_q, e_rt_q, e_imm_q;
  logic [W_AA_INSTR-1:0] e_pc_q;
  logic [W_PA_REG-1:0]   e_rd_q;

  logic                  upv_q, redir_q;
  logic [W_PD_DATA-1:0]  upt_q;
  logic [W_PA_REG-1:0]   pa_q;
  logic [W_AA_INSTR-1:0] target_q;

  logic [5:0]            op;
  logic                  busy, accept, mul_start, single, mul_done;
  logic [W_PD_DATA-1:0]  mul_prod, res_d;
  logic [W_AA_INSTR-1:0] target_d;
  logic                  wr_d, taken_d;
  logic [4:0]            shamt;

  assign op        = 6'(e_uops_q);
  assign busy      = (state_q == MUL) || (e_vld_q && op == UOP_MUL);
  assign accept    = (DFI_PD_uops != {W_PD_UOPS{1'b1}}) && !busy && !CFI_PC_clear;
  assign mul_start = (state_q == IDLE) && e_vld_q && (op == UOP_MUL);
  assign single    = (state_q == IDLE) && e_vld_q && (op != UOP_MUL);
  assign shamt     = e_rt_q[4:0];
  assign target_d  = e_pc_q + W_AA_INSTR'(e_imm_q);

  always_comb begin
    res_d   = '0;
    wr_d    = 1'b1;
    taken_d = 1'b0;
    case (op)
      UOP_ADD:   res_d = e_rs_q + e_rt_q;
      UOP_SUB:   res_d = e_rs_q - e_rt_q;
      UOP_AND:   res_d = e_rs_q & e_rt_q;
      UOP_OR:    res_d = e_rs_q | e_rt_q;
      UOP_XOR:   res_d = e_rs_q ^ e_rt_q;
      UOP_SLT:   res_d = W_PD_DATA'($signed(e_rs_q) < $signed(e_rt_q));
      UOP_SLTU:  res_d = W_PD_DATA'(e_rs_q < e_rt_q);
      UOP_SLL:   res_d = e_rs_q << shamt;
      UOP_SRL:   res_d = e_rs_q >> shamt;
      UOP_SRA:   res_d = $unsigned($signed(e_rs_q) >>> shamt);
      UOP_ADDI:  res_d = e_rs_q + e_imm_q;
      UOP_LUI:   res_d = e_imm_q;
      UOP_AUIPC: res_d = W_PD_DATA'(e_pc_q) + e_imm_q;
      UOP_JAL: begin
        res_d   = W_PD_DATA'(e_pc_q + W_AA_INSTR'(32'd4));
        taken_d = 1'b1;
      end
      UOP_BEQ: begin
        wr_d    = 1'b0;
        taken_d = (e_rs_q == e_rt_q);
      end
      UOP_BNE: begin
        wr_d    = 1'b0;
        taken_d = (e_rs_q != e_rt_q);
      end
      default:   wr_d = 1'b0;
    endcase
  end

  mul_seq #(
    .Width (W_PD_DATA),
    .Iter  (MUL_ITER)
  ) u_mul_seq (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clear_i   (CFI_PC_clear),
    .start_i   (mul_start),
    .a_i       (e_rs_q),
    .b_i       (e_rt_q),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      e_vld_q  <= 1'b0;
      e_uops_q <= '0;
      e_rs_q   <= '0;
      e_rt_q   <= '0;
      e_imm_q  <= '0;
      e_pc_q   <= '0;
      e_rd_q   <= '0;
      upv_q    <= 1'b0;
      redir_q  <= 1'b0;
      upt_q    <= '0;
      pa_q     <= '0;
      target_q <= '0;
    end else if (CFI_PC_clear) begin
      state_q <= IDLE;
      e_vld_q <= 1'b0;
      upv_q   <= 1'b0;
      redir_q <= 1'b0;
    end else begin
      upv_q   <= 1'b0;
      redir_q <= 1'b0;
      case (state_q)
        IDLE: if (mul_start) state_q <= MUL;
        MUL: begin
          if (mul_done) begin
            state_q <= IDLE;
            e_vld_q <= 1'b0;
            upv_q   <= (e_rd_q != '0);
            upt_q   <= mul_prod;
            pa_q    <= e_rd_q;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (single) begin
        e_vld_q <= 1'b0;
        upv_q   <= wr_d && (e_rd_q != '0);
        if (wr_d && (e_rd_q != '0)) begin
          upt_q <= res_d;
          pa_q  <= e_rd_q;
        end
        redir_q <= taken_d;
        if (taken_d) target_q <= target_d;
      end
      // Only reachable when E is empty or draining a single-cycle op this same edge.
      if (accept) begin
        e_vld_q  <= 1'b1;
        e_uops_q <= DFI_PD_uops;
        e_rs_q   <= DFI_PD_rs;
        e_rt_q   <= DFI_PD_rt;
        e_imm_q  <= DFI_PD_imm;
        e_pc_q   <= DFI_AA_pc;
        e_rd_q   <= DFI_PA_rd;
      end
    end
  end

  assign CFO_PC_busy     = busy;
  assign CDO_PD_upt      = upt_q;
  assign CDO_PA_upt      = pa_q;
  assign CDO_PC_upv      = upv_q;
  assign CFO_PC_redirect = redir_q;
  assign DFO_AA_target   = target_q;

endmodule

// File: tb/tb_exe_pip1.sv
// Scoreboard bench for exe_pip1: directed ops push expected broadcasts/redirects with the
// cycle they must appear; a negedge monitor pops and compares them against the DUT.
module tb_exe_pip1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  uops = 6'h3F;
  logic [31:0] rs = '0, rt = '0, imm = '0, pc = '0;
  logic [4:0]  rd = '0;
  logic        clear = 1'b0;
  logic        busy, upv, redir;
  logic [31:0] upt, target;
  logic [4:0]  pa;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [4:0]  rd;
  } wb_t;

  typedef struct {
    int          cyc;
    logic [31:0] tgt;
  } rdr_t;

  wb_t  exp_wb[$];
  rdr_t exp_rd[$];
  wb_t  mon_wb;
  rdr_t mon_rd;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   w;

  exe_pip1 dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .DFI_PD_uops     (uops),
    .DFI_PD_rs       (rs),
    .DFI_PD_rt       (rt),
    .DFI_PD_imm      (imm),
    .DFI_AA_pc       (pc),
    .DFI_PA_rd       (rd),
    .CFI_PC_clear    (clear),
    .CFO_PC_busy     (busy),
    .CDO_PD_upt      (upt),
    .CDO_PA_upt      (pa),
    .CDO_PC_upv      (upv),
    .CFO_PC_redirect (redir),
    .DFO_AA_target   (target)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every broadcast/redirect against the head of its queue, and flag
  // expectations whose cycle passed without the DUT presenting them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_wb.size() > 0 && exp_wb[0].cyc < cyc) begin
        checks++; errors++;
        mon_wb = exp_wb.pop_front();
        $display("FAIL wb_missing: no upv at cyc %0d, required upt=%h rd=%0d",
                 mon_wb.cyc, mon_wb.data, mon_wb.rd);
      end
      if (exp_rd.size() > 0 && exp_rd[0].cyc < cyc) begin
        checks++; errors++;
        mon_rd = exp_rd.pop_front();
        $display("FAIL redirect_missing: no redirect at cyc %0d, required target=%h",
                 mon_rd.cyc, mon_rd.tgt);
      end
      if (upv) begin
        checks++;
        if (exp_wb.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected: got upt=%h rd=%0d at cyc %0d, required no upv",
                   upt, pa, cyc);
        end else begin
          mon_wb = exp_wb.pop_front();
          if (mon_wb.cyc != cyc || mon_wb.data !== upt || mon_wb.rd !== pa) begin
            errors++;
            $display("FAIL wb: got cyc=%0d upt=%h rd=%0d, required cyc=%0d upt=%h rd=%0d",
                     cyc, upt, pa, mon_wb.cyc, mon_wb.data, mon_wb.rd);
          end
        end
      end
      if (redir) begin
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL redirect_unexpected: got target=%h at cyc %0d, required none",
                   target, cyc);
        end else begin
          mon_rd = exp_rd.pop_front();
          if (mon_rd.cyc != cyc || mon_rd.tgt !== target) begin
            errors++;
            $display("FAIL redirect: got cyc=%0d target=%h, required cyc=%0d target=%h",
                     cyc, target, mon_rd.cyc, mon_rd.tgt);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Present an op at a negedge, hold it while busy, then queue its expected results.
  task automatic issue(input logic [5:0] u, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] p, input logic [4:0] r,
                       input bit push_wb, input logic [31:0] wbv,
                       input bit push_rd, input logic [31:0] tgt, output int waits);
    int lat;
    uops = u; rs = a; rt = b; imm = im; pc = p; rd = r;
    waits = 0;
    while (busy && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 100) begin
      checks++; errors++;
      $display("FAIL issue_timeout: busy still 1 after %0d cycles, required 0", waits);
    end
    lat = (u == 6'd16) ? 34 : 2;
    if (push_wb) exp_wb.push_back('{cyc + lat, wbv, r});
    if (push_rd) exp_rd.push_back('{cyc + lat, tgt});
    @(negedge clk);
    uops = 6'h3F;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_upv", 32'(upv), 32'd0);
    chk("rst_redirect", 32'(redir), 32'd0);
    chk("rst_upt", upt, 32'd0);
    chk("rst_pa", 32'(pa), 32'd0);
    chk("rst_target", target, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    issue(6'd0, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 1, 32'd12, 0, 32'd0, w);
    repeat (3) @(negedge clk);

    // Back-to-back single-cycle ops
    issue(6'd1, 32'd0, 32'd1, 32'd0, 32'd0, 5'd4, 1, 32'hFFFF_FFFF, 0, 32'd0, w);
    issue(6'd9, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 5'd5, 1, 32'hF800_0000, 0, 32'd0, w);
    issue(6'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd8, 1, 32'd1, 0, 32'd0, w);
    issue(6'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd9, 1, 32'd0, 0, 32'd0, w);
    issue(6'd7, 32'd1, 32'h21, 32'd0, 32'd0, 5'd10, 1, 32'd2, 0, 32'd0, w);
    issue(6'd11, 32'd0, 32'd0, 32'h1234_5000, 32'd0, 5'd11, 1, 32'h1234_5000, 0, 32'd0, w);
    issue(6'd12, 32'd0, 32'd0, 32'h10, 32'h1000, 5'd12, 1, 32'h1010, 0, 32'd0, w);
    issue(6'd4, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 5'd13, 1, 32'h0FF0, 0, 32'd0, w);
    issue(6'd8, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 5'd14, 1, 32'h0800_0000, 0, 32'd0, w);
    issue(6'd2, 32'hC, 32'hA, 32'd0, 32'd0, 5'd15, 1, 32'h8, 0, 32'd0, w);
    issue(6'd3, 32'hC, 32'hA, 32'd0, 32'd0, 5'd16, 1, 32'hE, 0, 32'd0, w);
    issue(6'd20, 32'd1, 32'd1, 32'd0, 32'd0, 5'd17, 0, 32'd0, 0, 32'd0, w);
    repeat (3) @(negedge clk);

    // Multiply with a dependent ADD held upstream by busy
    issue(6'd16, 32'd3, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd6, 1, 32'hFFFF_FFFD, 0, 32'd0, w);
    issue(6'd0, 32'd1, 32'd2, 32'd0, 32'd0, 5'd7, 1, 32'd3, 0, 32'd0, w);
    chk("mul_busy_cycles", 32'(w), 32'd33);
    repeat (3) @(negedge clk);

    // Branches and jump
    issue(6'd14, 32'd9, 32'd9, 32'h20, 32'h100, 5'd0, 0, 32'd0, 1, 32'h120, w);
    issue(6'd15, 32'd9, 32'd9, 32'h20, 32'h100, 5'd0, 0, 32'd0, 0, 32'd0, w);
    issue(6'd15, 32'd9, 32'd8, 32'h40, 32'h200, 5'd0, 0, 32'd0, 1, 32'h240, w);
    issue(6'd10, 32'd5, 32'd0, 32'd6, 32'd0, 5'd0, 0, 32'd0, 0, 32'd0, w);
    issue(6'd13, 32'd0, 32'd0, 32'h10, 32'h40, 5'd1, 1, 32'h44, 1, 32'h50, w);
    repeat (3) @(negedge clk);
    chk("target_hold", target, 32'h50);

    // Clear at multiply cycle 10 with an ADD presented on the same edge
    issue(6'd16, 32'd5, 32'd5, 32'd0, 32'd0, 5'd20, 0, 32'd0, 0, 32'd0, w);
    repeat (9) @(negedge clk);
    uops = 6'd0; rs = 32'd1; rt = 32'd1; rd = 5'd21; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; uops = 6'h3F;
    chk("clear_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    chk("clear_busy_late", 32'(busy), 32'd0);

    // Asynchronous reset mid-multiply
    issue(6'd16, 32'd7, 32'd7, 32'd0, 32'd0, 5'd22, 0, 32'd0, 0, 32'd0, w);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_upt", upt, 32'd0);
    chk("arst_pa", 32'(pa), 32'd0);
    chk("arst_target", target, 32'd0);
    chk("arst_upv", 32'(upv), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(6'd0, 32'h10, 32'h20, 32'd0, 32'd0, 5'd2, 1, 32'h30, 0, 32'd0, w);
    repeat (40) @(negedge clk);

    chk("scoreboard_drained", 32'(exp_wb.size() + exp_rd.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_pip1.md
# exe_pip1

Pipeline-1 execute stage directly downstream of the pip1 reservation station. Accepts one issued micro-op per cycle (uops, rs, rt, imm, pc, rd), computes the result in a registered two-stage path (E → W), and broadcasts it back to the reservation station's update port. It also resolves branches. A 32-cycle iterative multiply holds the stage busy, which back-pressures issue.

## Interface
Parameters:
- W_PD_UOPS, 6, micro-op width; all-ones (6'h3F) = bubble
- W_PD_DATA, 32, data width
- W_PA_REG, 5, register address width
- W_AA_INSTR, 32, pc width
- MUL_ITER, 32, multiply iterations (must equal W_PD_DATA)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous and active-low
- DFI_PD_uops  in  W_PD_UOPS  issued micro-op; 6'h3F = no issue
- DFI_PD_rs / DFI_PD_rt / DFI_PD_imm  in  W_PD_DATA  operands
- DFI_AA_pc  in  W_AA_INSTR  pc of issued op
- DFI_PA_rd  in  W_PA_REG  destination register
- CFI_PC_clear  in  1  synchronous flush
- CFO_PC_busy  out  1  stage cannot accept this cycle
- CDO_PD_upt  out  W_PD_DATA  broadcast result
- CDO_PA_upt  out  W_PA_REG  broadcast destination
- CDO_PC_upv  out  1  broadcast valid
- CFO_PC_redirect  out  1  taken branch/jump, one-cycle pulse
- DFO_AA_target  out  W_AA_INSTR  redirect target

## Operation
- Accept: on an edge where uops != 6'h3F and CFO_PC_busy = 0, the op latches into the E register (E_vld = 1). If busy = 1, input is ignored; the reservation station holds it.
- Uop codes (decimal):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLT (signed), 6 SLTU
  - 7 SLL, 8 SRL, 9 SRA; shift amount = rt[4:0]
  - 10 ADDI = rs+imm; 11 LUI = imm; 12 AUIPC = pc+imm
  - 13 JAL: rd ← pc+4, target = pc+imm
  - 14 BEQ, 15 BNE: target = pc+imm; no writeback
  - 16 MUL: low 32 bits of rs×rt
  - Any other code: executes as a NOP (no broadcast, no redirect).
- All adds wrap modulo 2^32. Signed comparison is on two's-complement values.
- FSM states:
  - IDLE: E holds a single-cycle op or is empty. Single-cycle ops move E → W on the next edge.
  - MUL: entered when E holds MUL. Shift-add runs for MUL_ITER cycles, then the product moves to W and the FSM returns to IDLE.
- CFO_PC_busy = (state == MUL) || (E_vld && E_uops == MUL). It is combinational from registers, never from inputs.
- W stage drives registered outputs:
  - CDO_PC_upv = 1 for exactly one cycle per completed writing op with rd != 0.
  - CFO_PC_redirect = 1 for one cycle for JAL, taken BEQ (rs==rt), or taken BNE (rs!=rt).
- CDO_PD_upt, CDO_PA_upt and DFO_AA_target hold their last values when not valid.
- Clear:
  - On an edge with CFI_PC_clear = 1, E_vld, W valid and redirect go to 0, the FSM goes to IDLE, and any partial product is discarded.
  - An op presented on the same edge is not accepted.
  - Clear has priority over every other event.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, E_vld = 0, CFO_PC_busy = 0, CDO_PC_upv = 0, CFO_PC_redirect = 0, CDO_PD_upt = 0, CDO_PA_upt = 0, DFO_AA_target = 0. Reset mid-multiply abandons the op.
- Single-cycle op accepted at edge N: result and valid are visible after edge N+1, for one cycle. Throughput is 1 op per cycle, back-to-back.
- MUL accepted at edge N:
  - busy is high from after edge N until after edge N+MUL_ITER+1.
  - upv is high after edge N+MUL_ITER+1.
  - The next op can be accepted at edge N+MUL_ITER+2.
- The op following a MUL is never lost: it is held upstream because busy = 1.

## Structure
- Package exe_pip1_pkg holds:
  - uop code constants (UOP_ADD … UOP_MUL, UOP_NOP = 6'h3F)
  - FSM state enum {IDLE, MUL}
- Sub-module mul_seq: iterative shift-add multiplier with start/done handshake, MUL_ITER-cycle latency, clear input. It is instantiated once.

## Test plan
- Reset release, then ADD rs=5, rt=7, rd=3 at edge N → after N+1: upv=1, upt=12, upt addr=3; upv=0 one cycle later.
- SUB 0−1 then SRA 0x80000000 by 4, back-to-back → upt 0xFFFFFFFF, then 0xF8000000, on consecutive cycles.
- MUL 3×0xFFFFFFFF, then ADD held upstream → busy high 33 cycles, upt=0xFFFFFFFD; ADD accepted the cycle busy falls.
- BEQ rs=rt=9, pc=0x100, imm=0x20 → redirect pulse, target=0x120, upv=0. BNE with the same operands → no redirect.
- ADDI with rd=0 → no upv. JAL pc=0x40, rd=1 → upt=0x44, redirect, target=pc+imm.
- Clear asserted at MUL cycle 10, with an ADD presented on the same edge → no broadcast, busy=0 next cycle, ADD not accepted. Separately, rst_n pulsed mid-MUL → all outputs 0 immediately.
